sub_group_serial: RTL and testbench

//  Multi-cycle group-serial subtractor, the inverse companion of the group CLA adder.
//  - Computes result = {borrow_out, a - b - bin}.
//  - Processes GROUPSIZE bits per cycle, LSB group first, with a registered borrow between groups.
//  - Sits beside the adder in the ALU datapath wherever area matters more than latency.
//  - Valid/ready handshake on the input side and on the output side.

---
 rtl/sub_group_serial.sv | 115 +++++++++++
 tb/tb_sub_group_serial.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sub_group_serial.sv
// sub_group_serial: group-serial subtractor producing {borrow_out, a - b - bin}, GROUPSIZE bits per cycle.
// Defining SUB_OVF_EN adds the registered signed-overflow output ovf.
module sub_group_serial #(
    parameter int INPUTSIZE = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INPUTSIZE-1:0] a,
    input  logic [INPUTSIZE-1:0] b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INPUTSIZE:0]   result
`ifdef SUB_OVF_EN
    ,
    output logic                 ovf
`endif
);
    localparam int N  = INPUTSIZE / GROUPSIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (INPUTSIZE % GROUPSIZE != 0) begin : g_size_check
        $error("sub_group_serial: INPUTSIZE must be a multiple of GROUPSIZE");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [INPUTSIZE-1:0] a_q, a_d, b_q, b_d;
    logic                 borrow_q, borrow_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [INPUTSIZE:0]   res_q, res_d;
    logic [31:0]          base;
    logic [GROUPSIZE:0]   grp;
    logic                 last;
`ifdef SUB_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    // One group per cycle; the extra top bit of grp is the borrow out of the group.
    assign base = 32'(cnt_q) * GROUPSIZE;
    assign grp  = {1'b0, a_q[base +: GROUPSIZE]} - {1'b0, b_q[base +: GROUPSIZE]}
                - (GROUPSIZE+1)'(borrow_q);
    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifdef SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d  = BUSY;
                a_d      = a;
                b_d      = b;
                borrow_d = bin;
                cnt_d    = '0;
            end
            BUSY: begin
                res_d[base +: GROUPSIZE] = grp[GROUPSIZE-1:0];
                res_d[INPUTSIZE]         = grp[GROUPSIZE];
                borrow_d                 = grp[GROUPSIZE];
                cnt_d                    = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
`ifdef SUB_OVF_EN
                    ovf_d   = (a_q[INPUTSIZE-1] != b_q[INPUTSIZE-1])
                           && (grp[GROUPSIZE-1] != a_q[INPUTSIZE-1]);
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
`ifdef SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
`ifdef SUB_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_sub_group_serial.sv
// tb_sub_group_serial: directed vectors with a scoreboard queue checked by an independent output monitor.
// Checks ovf as well when SUB_OVF_EN is defined.
module tb_sub_group_serial;
    logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [32:0] result;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif

    typedef struct {logic [32:0] res; logic ovf; int acc;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   total = 0, bad = 0, cyc = 0;
    logic ov_prev = 1'b0;

    sub_group_serial #(.INPUTSIZE(32), .GROUPSIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
`ifdef SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: latency on each rising out_valid, result/ovf on each output handshake.
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) fail("spurious_out_valid");
            else chk("latency", 64'(cyc - sb[0].acc), 64'd8);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) fail("unexpected_result");
            else begin
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
`ifdef SUB_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
        ov_prev = out_valid;
    end

    task automatic op(input logic [31:0] xa, input logic [31:0] xb, input logic xbin,
                      input logic [32:0] er, input logic eo);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout");
            return;
        end
        in_valid = 1'b1; a = xa; b = xb; bin = xbin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{er, eo, cyc});
    endtask

    task automatic drain;
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) fail("drain_timeout");
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        op(32'd5,          32'd3,          1'b0, 33'h0_00000002, 1'b0);
        op(32'd0,          32'd1,          1'b0, 33'h1_FFFFFFFF, 1'b0);
        op(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 33'h1_FFFFFFFF, 1'b0);
        op(32'h12345678,   32'h02345678,   1'b0, 33'h0_10000000, 1'b0);
        op(32'h80000000,   32'd1,          1'b0, 33'h0_7FFFFFFF, 1'b1);
        op(32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 33'h1_80000000, 1'b1);
        op(32'd10,         32'd3,          1'b1, 33'h0_00000006, 1'b0);
        drain();

        // Back-pressure in DONE; in_valid pulses meanwhile must be ignored.
        out_ready = 1'b0;
        op(32'd100, 32'd1, 1'b0, 33'h0_00000063, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail("done_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result), 64'h0_00000063);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            in_valid = (i == 1 || i == 2);
            a = 32'd7; b = 32'd7;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);

        // Abort in the third BUSY cycle.
        in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'd1; bin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(32'd9, 32'd4, 1'b0, 33'h0_00000005, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
